// File: rtl/step_ramp_generator.sv
// Step/dir/en motion front end: runs a commanded step count with a linear
// accel/cruise/decel period ramp and tracks signed absolute position.
module step_ramp_generator #(
  parameter int COUNT_W      = 24,
  parameter int PERIOD_W     = 20,
  parameter int POS_W        = 32,
  parameter int START_PERIOD = 100,
  parameter int MIN_PERIOD   = 40,
  parameter int ACCEL_DEC    = 20,
  parameter int PULSE_W      = 4,
  parameter int SETUP_CYC    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COUNT_W-1:0] cmd_steps,
  input  logic               cmd_dir,
  input  logic               abort,
  input  logic               hold_en,
  output logic               step,
  output logic               dir,
  output logic               en,
  output logic               busy,
  output logic               done,
  output logic [POS_W-1:0]   position
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] ACCEL  = 3'd2;
  localparam logic [2:0] CRUISE = 3'd3;
  localparam logic [2:0] DECEL  = 3'd4;

  localparam logic [PERIOD_W:0]   START_X    = (PERIOD_W+1)'(START_PERIOD);
  localparam logic [PERIOD_W:0]   MIN_X      = (PERIOD_W+1)'(MIN_PERIOD);
  localparam logic [PERIOD_W:0]   ACC_X      = (PERIOD_W+1)'(ACCEL_DEC);
  localparam logic [PERIOD_W-1:0] START_P    = PERIOD_W'(START_PERIOD);
  localparam logic [PERIOD_W-1:0] MIN_P      = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] SETUP_LOAD = PERIOD_W'(SETUP_CYC - 1);
  localparam logic [PERIOD_W-1:0] PULSE_LOAD = PERIOD_W'(PULSE_W - 1);
  localparam logic [PERIOD_W-1:0] P_ONE      = PERIOD_W'(1);
  localparam logic [COUNT_W-1:0]  C_ONE      = COUNT_W'(1);
  localparam logic [COUNT_W:0]    CX_ONE     = (COUNT_W+1)'(1);

  logic [2:0]          state_reg, state_next;
  logic [PERIOD_W-1:0] timer_reg, timer_next;
  logic [PERIOD_W-1:0] period_reg, period_next;
  logic [PERIOD_W-1:0] pulse_reg, pulse_next;
  logic [COUNT_W-1:0]  remaining_reg, remaining_next;
  logic [COUNT_W-1:0]  ramp_reg, ramp_next;
  logic                step_next, dir_next, en_next, done_next;
  logic [POS_W-1:0]    position_next;

  logic [COUNT_W:0]    c_plus;
  logic [COUNT_W-1:0]  rem_eff, r_dec;
  logic [PERIOD_W:0]   up_x, dn_x;
  logic [PERIOD_W-1:0] up_c, dn_c;

  assign cmd_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);

  // Abort shortens the move so that exactly ramp_cnt+1 edges remain, which
  // is enough to walk the period back up to START_PERIOD.
  always_comb begin
    c_plus  = {1'b0, ramp_reg} + CX_ONE;
    rem_eff = remaining_reg;
    if (abort && ({1'b0, remaining_reg} > c_plus))
      rem_eff = c_plus[COUNT_W-1:0];
    r_dec = rem_eff - C_ONE;

    up_x = {1'b0, period_reg} + ACC_X;
    dn_x = {1'b0, period_reg} - ACC_X;
    if (up_x > START_X)    up_c = START_P;
    else if (up_x < MIN_X) up_c = MIN_P;
    else                   up_c = up_x[PERIOD_W-1:0];
    // A borrow out of the subtraction sets the top bit; treat it as underflow.
    if (dn_x[PERIOD_W] || dn_x < MIN_X) dn_c = MIN_P;
    else if (dn_x > START_X)            dn_c = START_P;
    else                                dn_c = dn_x[PERIOD_W-1:0];
  end

  always_comb begin
    state_next     = state_reg;
    timer_next     = timer_reg;
    period_next    = period_reg;
    pulse_next     = pulse_reg;
    remaining_next = remaining_reg;
    ramp_next      = ramp_reg;
    step_next      = step;
    dir_next       = dir;
    done_next      = 1'b0;
    position_next  = position;

    if (step) begin
      if (pulse_reg == '0) step_next = 1'b0;
      else                 pulse_next = pulse_reg - P_ONE;
    end

    if (state_reg == IDLE) begin
      if (cmd_valid) begin
        dir_next = cmd_dir;
        if (cmd_steps == '0) begin
          done_next = 1'b1;
        end else begin
          state_next     = SETUP;
          remaining_next = cmd_steps;
          period_next    = START_P;
          ramp_next      = '0;
          timer_next     = SETUP_LOAD;
        end
      end
    end else if (timer_reg != '0) begin
      timer_next     = timer_reg - P_ONE;
      remaining_next = rem_eff;
    end else if (remaining_reg == '0) begin
      done_next  = 1'b1;
      state_next = IDLE;
    end else begin
      // Step edge: the interval to the next edge uses the period in force now.
      step_next      = 1'b1;
      pulse_next     = PULSE_LOAD;
      position_next  = position + (dir ? POS_W'(1) : {POS_W{1'b1}});
      remaining_next = r_dec;
      timer_next     = period_reg - P_ONE;
      if (r_dec != '0) begin
        if (r_dec <= ramp_reg) begin
          state_next  = DECEL;
          period_next = up_c;
          ramp_next   = ramp_reg - C_ONE;
        end else if (state_reg == ACCEL || state_reg == SETUP) begin
          period_next = dn_c;
          ramp_next   = ramp_reg + C_ONE;
          state_next  = (dn_c == MIN_P) ? CRUISE : ACCEL;
        end
      end
    end

    en_next = (state_next != IDLE) || hold_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      period_reg    <= START_P;
      pulse_reg     <= '0;
      remaining_reg <= '0;
      ramp_reg      <= '0;
      step          <= 1'b0;
      dir           <= 1'b0;
      en            <= 1'b0;
      done          <= 1'b0;
      position      <= '0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      period_reg    <= period_next;
      pulse_reg     <= pulse_next;
      remaining_reg <= remaining_next;
      ramp_reg      <= ramp_next;
      step          <= step_next;
      dir           <= dir_next;
      en            <= en_next;
      done          <= done_next;
      position      <= position_next;
    end
  end

endmodule

// File: tb/tb_step_ramp_generator.sv
// Directed bench for step_ramp_generator: table of moves with hand-computed
// edge intervals, plus reset-mid-pulse and back-to-back command sequences.
module tb_step_ramp_generator;
  localparam int SETUP_CYC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_dir = 1'b0;
  logic        abort = 1'b0;
  logic        hold_en = 1'b0;
  logic [23:0] cmd_steps = '0;
  logic        cmd_ready, step, dir, en, busy, done;
  logic [31:0] position;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int exp_pos  = 0;

  typedef struct packed {
    int              steps;
    logic            dir;
    logic            hold;
    int              abort_edge;  // -1 none, -2 with the command, else edges seen
    int              abort_dly;   // cycles after that edge
    int              n_edges;
    logic [0:9][7:0] ival;        // intervals between consecutive edges
    int              final_wait;  // last edge to done
  } vec_t;

  vec_t vecs [8];

  step_ramp_generator dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .abort(abort), .hold_en(hold_en),
    .step(step), .dir(dir), .en(en), .busy(busy), .done(done), .position(position)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic run_move(input vec_t v, input int idx);
    int  k, edges, last_edge;
    bit  prev_step, got_done;
    k = 0; edges = 0; last_edge = 0; got_done = 0;
    @(negedge clk);
    check($sformatf("v%0d_ready_idle", idx), int'(cmd_ready), 1);
    hold_en   = v.hold;
    cmd_valid = 1'b1;
    cmd_steps = v.steps[23:0];
    cmd_dir   = v.dir;
    abort     = (v.abort_edge == -2);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    check($sformatf("v%0d_busy_after_accept", idx), int'(busy), (v.steps != 0) ? 1 : 0);
    prev_step = step;
    while (k < 3000) begin
      if (step && !prev_step) begin
        if (edges == 0) begin
          check($sformatf("v%0d_first_edge", idx), k, SETUP_CYC);
          check($sformatf("v%0d_en_moving", idx), int'(en), 1);
          check($sformatf("v%0d_dir", idx), int'(dir), int'(v.dir));
        end else if (edges <= 9) begin
          check($sformatf("v%0d_interval%0d", idx, edges), k - last_edge, int'(v.ival[edges-1]));
        end
        edges++;
        last_edge = k;
      end
      prev_step = step;
      if (done) begin
        got_done = 1;
        break;
      end
      abort = (v.abort_edge >= 0 && edges == v.abort_edge && k == last_edge + v.abort_dly);
      @(posedge clk); #1;
      k++;
    end
    abort = 1'b0;
    exp_pos += v.dir ? v.n_edges : -v.n_edges;
    check($sformatf("v%0d_done_seen", idx), int'(got_done), 1);
    check($sformatf("v%0d_edges", idx), edges, v.n_edges);
    if (v.n_edges == 0) check($sformatf("v%0d_done_latency", idx), k, 0);
    else check($sformatf("v%0d_final_wait", idx), k - last_edge, v.final_wait);
    check($sformatf("v%0d_busy_at_done", idx), int'(busy), 0);
    check($sformatf("v%0d_ready_at_done", idx), int'(cmd_ready), 1);
    check($sformatf("v%0d_en_at_done", idx), int'(en), int'(v.hold));
    check($sformatf("v%0d_position", idx), int'($signed(position)), exp_pos);
    @(posedge clk); #1;
    check($sformatf("v%0d_done_one_cycle", idx), int'(done), 0);
    check($sformatf("v%0d_busy_after_done", idx), int'(busy), 0);
  endtask

  initial begin
    int   k, d1, e2, d2;
    bit   prev;
    vec_t one;

    vecs[0] = '{steps:10, dir:1'b1, hold:1'b0, abort_edge:-1, abort_dly:0, n_edges:10,
                ival:{8'd100, 8'd80, 8'd60, 8'd40, 8'd40, 8'd40, 8'd40, 8'd60, 8'd80, 8'd0},
                final_wait:100};
    vecs[1] = '{steps:3, dir:1'b0, hold:1'b1, abort_edge:-1, abort_dly:0, n_edges:3,
                ival:{8'd100, 8'd80, 64'd0}, final_wait:100};
    vecs[2] = '{steps:0, dir:1'b1, hold:1'b0, abort_edge:-1, abort_dly:0, n_edges:0,
                ival:80'd0, final_wait:0};
    vecs[3] = '{steps:7, dir:1'b0, hold:1'b1, abort_edge:-1, abort_dly:0, n_edges:7,
                ival:{8'd100, 8'd80, 8'd60, 8'd40, 8'd60, 8'd80, 32'd0}, final_wait:100};
    vecs[4] = '{steps:1, dir:1'b1, hold:1'b0, abort_edge:-1, abort_dly:0, n_edges:1,
                ival:80'd0, final_wait:100};
    vecs[5] = '{steps:100, dir:1'b1, hold:1'b0, abort_edge:5, abort_dly:3, n_edges:9,
                ival:{8'd100, 8'd80, 8'd60, 8'd40, 8'd40, 8'd40, 8'd60, 8'd80, 16'd0},
                final_wait:100};
    vecs[6] = '{steps:50, dir:1'b0, hold:1'b1, abort_edge:0, abort_dly:0, n_edges:1,
                ival:80'd0, final_wait:100};
    vecs[7] = '{steps:3, dir:1'b1, hold:1'b0, abort_edge:-2, abort_dly:0, n_edges:3,
                ival:{8'd100, 8'd80, 64'd0}, final_wait:100};

    #2 rst_n = 1'b0;
    #1;
    check("rst_step", int'(step), 0);
    check("rst_en", int'(en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_dir", int'(dir), 0);
    check("rst_position", int'($signed(position)), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_move(vecs[i], i);
      $display("move %0d: steps=%0d dir=%0d done, position=%0d", i, vecs[i].steps,
               vecs[i].dir, $signed(position));
    end

    // Reset while step is high discards the move immediately.
    @(negedge clk);
    hold_en = 1'b1; cmd_valid = 1'b1; cmd_steps = 24'd20; cmd_dir = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && !step; i++) begin
      @(posedge clk); #1;
    end
    check("rst_mid_step_high", int'(step), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_step", int'(step), 0);
    check("rst_mid_en", int'(en), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_position", int'($signed(position)), 0);
    check("rst_mid_ready", int'(cmd_ready), 1);
    exp_pos = 0;
    @(negedge clk);
    rst_n = 1'b1;
    hold_en = 1'b0;
    one = vecs[4];
    run_move(one, 8);
    $display("move 8: single step after reset, position=%0d", $signed(position));

    // Back-to-back: cmd_valid held high, second accept on the done cycle.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_steps = 24'd1; cmd_dir = 1'b0;
    @(posedge clk); #1;
    k = 0; d1 = -1; e2 = -1; d2 = -1;
    prev = step;
    while (k < 2000 && d2 < 0) begin
      if (d1 >= 0 && step && !prev && e2 < 0) e2 = k;
      if (done) begin
        if (d1 < 0) begin
          d1 = k;
          check("b2b_ready_on_done", int'(cmd_ready), 1);
        end else if (k > d1) begin
          d2 = k;
        end
      end
      if (d1 >= 0 && k == d1 + 1) begin
        cmd_valid = 1'b0;
        check("b2b_busy_after_second_accept", int'(busy), 1);
      end
      prev = step;
      if (d2 < 0) begin
        @(posedge clk); #1;
        k++;
      end
    end
    cmd_valid = 1'b0;
    exp_pos -= 2;
    check("b2b_second_done_seen", int'(d2 >= 0), 1);
    check("b2b_first_edge_after_done", e2 - d1, SETUP_CYC + 1);
    check("b2b_final_wait", d2 - e2, 100);
    check("b2b_position", int'($signed(position)), exp_pos);
    $display("move 9-10: back-to-back, done1=%0d edge2=%0d done2=%0d", d1, e2, d2);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
